// File: rtl/dae_issuer_if.sv
// Bundle of every non-clock signal between the program issuer and its
// surroundings: program write port, run control, ALU operand/result wires,
// the valid/ready result stream and the status flags.
// The master side is the issuer itself; the slave side is the board or bench.
interface dae_issuer_if #(
   parameter int DATA_W = 4,
   parameter int OP_W   = 3,
   parameter int IDX_W  = 3,
   parameter int LEN_W  = 4
);

   logic              wr_en;
   logic [IDX_W-1:0]  wr_addr;
   logic [OP_W-1:0]   wr_sel;
   logic [DATA_W-1:0] wr_rs;
   logic [DATA_W-1:0] wr_rt;

   logic              start;
   logic [LEN_W-1:0]  len;

   logic [DATA_W-1:0] rs_out;
   logic [DATA_W-1:0] rt_out;
   logic [OP_W-1:0]   sel_out;
   logic [DATA_W-1:0] rd_in;

   logic              res_valid;
   logic              res_ready;
   logic [IDX_W-1:0]  res_idx;
   logic [DATA_W-1:0] res_data;

   logic              busy;
   logic              done;

   modport master (
      input  wr_en, wr_addr, wr_sel, wr_rs, wr_rt,
      input  start, len,
      output rs_out, rt_out, sel_out,
      input  rd_in,
      output res_valid,
      input  res_ready,
      output res_idx, res_data,
      output busy, done
   );

   modport slave (
      output wr_en, wr_addr, wr_sel, wr_rs, wr_rt,
      output start, len,
      input  rs_out, rt_out, sel_out,
      output rd_in,
      input  res_valid,
      output res_ready,
      input  res_idx, res_data,
      input  busy, done
   );

endinterface

// File: rtl/dae_issuer.sv
// Program sequencer for the 4-bit decode-and-execute ALU.
// Stores up to PROG_DEPTH {sel, rs, rt} triples, plays them out one at a
// time on registered operand outputs, gives the combinational ALU one full
// cycle to settle, captures rd and hands it out on a valid/ready port.
module dae_issuer #(
   parameter int PROG_DEPTH = 8,
   parameter int DATA_W     = 4,
   parameter int OP_W       = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   dae_issuer_if.master bus
);

   localparam int IDX_W = $clog2(PROG_DEPTH);
   localparam int LEN_W = 4;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PROG_DEPTH);

   typedef struct packed {
      logic [OP_W-1:0]   sel;
      logic [DATA_W-1:0] rs;
      logic [DATA_W-1:0] rt;
   } entry_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;

   entry_t            mem [PROG_DEPTH];

   entry_t            op_q;
   logic [IDX_W-1:0]  pc_q;
   logic [IDX_W-1:0]  pc_inc;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  len_clamped;
   logic              last_entry;

   logic              res_valid_q;
   logic [IDX_W-1:0]  res_idx_q;
   logic [DATA_W-1:0] res_data_q;
   logic              busy_q;
   logic              done_q;

   logic              start_run;
   logic              zero_run;
   logic              capture;
   logic              advance;
   logic              finish;

   // Lengths beyond the program size run the whole program.
   assign len_clamped = (bus.len > MAX_LEN) ? MAX_LEN : bus.len;

   // pc never reaches the top entry and then advances, so the wrap of the
   // increment is harmless.
   assign pc_inc      = pc_q + 1'b1;
   assign last_entry  = (LEN_W'(pc_q) == (len_q - LEN_W'(1)));

   assign bus.rs_out    = op_q.rs;
   assign bus.rt_out    = op_q.rt;
   assign bus.sel_out   = op_q.sel;
   assign bus.res_valid = res_valid_q;
   assign bus.res_idx   = res_idx_q;
   assign bus.res_data  = res_data_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

   // State register; reset abandons any run in progress.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode plus the one-cycle strobes that steer the datapath.
   always_comb begin
      state_d   = state_q;
      start_run = 1'b0;
      zero_run  = 1'b0;
      capture   = 1'b0;
      advance   = 1'b0;
      finish    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (len_clamped == '0) begin
                  zero_run = 1'b1;
               end else begin
                  start_run = 1'b1;
                  state_d   = SETTLE;
               end
            end
         end
         SETTLE: begin
            capture = 1'b1;
            state_d = HOLD;
         end
         HOLD: begin
            if (res_valid_q && bus.res_ready) begin
               if (last_entry) begin
                  finish  = 1'b1;
                  state_d = IDLE;
               end else begin
                  advance = 1'b1;
                  state_d = SETTLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Program store: cleared on reset, writable only while no run is active.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < PROG_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (bus.wr_en && !busy_q) begin
         mem[bus.wr_addr] <= '{sel: bus.wr_sel, rs: bus.wr_rs, rt: bus.wr_rt};
      end
   end

   // Run bookkeeping: program counter, latched length and the status flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q   <= '0;
         len_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         if (zero_run) begin
            done_q <= 1'b1;
         end
         if (start_run) begin
            pc_q   <= '0;
            len_q  <= len_clamped;
            busy_q <= 1'b1;
            done_q <= 1'b0;
         end
         if (advance) begin
            pc_q <= pc_inc;
         end
         if (finish) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
         end
      end
   end

   // Operand registers feeding the ALU; they keep the last entry after a run.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q <= '0;
      end else if (start_run) begin
         op_q <= mem[0];
      end else if (advance) begin
         op_q <= mem[pc_inc];
      end
   end

   // Result capture after the settle cycle, released on the handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_valid_q <= 1'b0;
         res_idx_q   <= '0;
         res_data_q  <= '0;
      end else if (capture) begin
         res_valid_q <= 1'b1;
         res_idx_q   <= pc_q;
         res_data_q  <= bus.rd_in;
      end else if (advance || finish) begin
         res_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dae_issuer.sv
// Bench for dae_issuer: a behavioural ALU answers the operand outputs, a
// shadow copy of the program predicts each run, expected results queue up
// at start and a negedge monitor checks every presented result.
module tb_dae_issuer;

   typedef struct packed {
      logic [2:0] sel;
      logic [3:0] rs;
      logic [3:0] rt;
   } prog_t;

   typedef struct packed {
      logic [2:0] idx;
      logic [3:0] data;
      logic [2:0] sel;
      logic [3:0] rs;
      logic [3:0] rt;
   } exp_t;

   logic  clk = 1'b0;
   logic  rst_n = 1'b0;
   int    total = 0;
   int    bad = 0;
   exp_t  sb_q[$];
   prog_t shadow [8];
   bit    rand_ready = 1'b0;
   bit    ready_force = 1'b1;
   bit    rnd_bit = 1'b1;

   dae_issuer_if bus ();

   dae_issuer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ALU behaviour, straight from the opcode table.
   function automatic logic [3:0] alu(input logic [2:0] sel, input logic [3:0] rs, input logic [3:0] rt);
      logic signed [3:0] srt;
      srt = rt;
      case (sel)
         3'd0: return rs - rt;
         3'd1: return rs + rt;
         3'd2: return rs | rt;
         3'd3: return rs & rt;
         3'd4: return srt >>> 1;
         3'd5: return {rs[2:0], rs[3]};
         3'd6: return {3'b101, rs < rt};
         default: return {3'b111, rs == rt};
      endcase
   endfunction

   assign bus.rd_in     = alu(bus.sel_out, bus.rs_out, bus.rt_out);
   assign bus.res_ready = rand_ready ? rnd_bit : ready_force;

   // Free-running clock.
   always #5 clk = ~clk;

   // Random ready source, changed well clear of both clock edges.
   always @(posedge clk) begin
      #2;
      rnd_bit = 1'($urandom_range(0, 1));
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Monitor: every presented result must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.res_valid) begin
         checkOutput("sb_has_entry", int'(sb_q.size() != 0), 1);
         if (sb_q.size() != 0) begin
            e = sb_q[0];
            checkOutput("res_idx", bus.res_idx, e.idx);
            checkOutput("res_data", bus.res_data, e.data);
            checkOutput("op_sel", bus.sel_out, e.sel);
            checkOutput("op_rs", bus.rs_out, e.rs);
            checkOutput("op_rt", bus.rt_out, e.rt);
            if (bus.res_ready) begin
               void'(sb_q.pop_front());
            end
         end
      end
   end

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_rs_out"}, bus.rs_out, 0);
      checkOutput({tag, "_rt_out"}, bus.rt_out, 0);
      checkOutput({tag, "_sel_out"}, bus.sel_out, 0);
      checkOutput({tag, "_res_valid"}, bus.res_valid, 0);
      checkOutput({tag, "_res_idx"}, bus.res_idx, 0);
      checkOutput({tag, "_res_data"}, bus.res_data, 0);
      checkOutput({tag, "_busy"}, bus.busy, 0);
      checkOutput({tag, "_done"}, bus.done, 0);
   endtask

   task automatic applyReset();
      rst_n = 1'b0;
      stepCycle();
      stepCycle();
      rst_n = 1'b1;
      sb_q.delete();
      for (int i = 0; i < 8; i++) shadow[i] = '0;
   endtask

   task automatic writeEntry(input int addr, input int sel, input int rs, input int rt);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 3'(addr);
      bus.wr_sel  = 3'(sel);
      bus.wr_rs   = 4'(rs);
      bus.wr_rt   = 4'(rt);
      stepCycle();
      bus.wr_en = 1'b0;
      shadow[addr] = '{sel: 3'(sel), rs: 4'(rs), rt: 4'(rt)};
   endtask

   task automatic loadDemo();
      writeEntry(0, 1, 3, 4);
      writeEntry(1, 0, 2, 5);
      writeEntry(2, 4, 0, 8);
      writeEntry(3, 5, 9, 0);
      writeEntry(4, 6, 2, 5);
      writeEntry(5, 7, 5, 5);
   endtask

   task automatic queueRun(input int eff);
      exp_t e;
      for (int k = 0; k < eff; k++) begin
         e.idx  = 3'(k);
         e.sel  = shadow[k].sel;
         e.rs   = shadow[k].rs;
         e.rt   = shadow[k].rt;
         e.data = alu(shadow[k].sel, shadow[k].rs, shadow[k].rt);
         sb_q.push_back(e);
      end
   endtask

   // One run: queue its expectations, start it, wait (bounded) for done.
   // inject drives a write and a start mid-run; same_edge writes entry 0 on the start edge.
   task automatic applyStimulus(input int n, input bit check_timing, input bit inject, input bit same_edge);
      int    eff;
      int    c;
      bit    seen;
      prog_t fresh;
      eff = (n > 8) ? 8 : n;
      queueRun(eff);
      bus.start = 1'b1;
      bus.len   = 4'(n);
      if (same_edge) begin
         fresh = prog_t'($urandom);
         bus.wr_en   = 1'b1;
         bus.wr_addr = 3'd0;
         bus.wr_sel  = fresh.sel;
         bus.wr_rs   = fresh.rs;
         bus.wr_rt   = fresh.rt;
      end
      stepCycle();
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      bus.len   = 4'($urandom);
      if (same_edge) shadow[0] = fresh;
      if (eff == 0) begin
         checkOutput("zero_done", bus.done, 1);
         checkOutput("zero_busy", bus.busy, 0);
         for (int i = 0; i < 2; i++) begin
            stepCycle();
            checkOutput("zero_busy_hold", bus.busy, 0);
            checkOutput("zero_done_hold", bus.done, 1);
         end
         return;
      end
      checkOutput("run_busy", bus.busy, 1);
      checkOutput("run_done_clear", bus.done, 0);
      c = 0;
      seen = 1'b0;
      while (!seen && c < 400) begin
         stepCycle();
         c++;
         seen = bus.done;
         if (inject && c == 3) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 3'd2;
            bus.wr_sel  = 3'd1;
            bus.wr_rs   = 4'd7;
            bus.wr_rt   = 4'd7;
            bus.start   = 1'b1;
            bus.len     = 4'd1;
         end else if (inject && c == 4) begin
            bus.wr_en = 1'b0;
            bus.start = 1'b0;
         end
      end
      checkOutput("done_seen", seen, 1);
      if (check_timing) checkOutput("done_latency", c, 2 * eff);
      checkOutput("sb_drained", sb_q.size(), 0);
      checkOutput("busy_after", bus.busy, 0);
      checkOutput("last_rs_kept", bus.rs_out, shadow[eff-1].rs);
      checkOutput("last_sel_kept", bus.sel_out, shadow[eff-1].sel);
   endtask

   // Stall idx1 for five cycles and check it holds, then resume.
   task automatic applyBackpressure();
      int  c;
      bit  seen;
      queueRun(6);
      bus.start = 1'b1;
      bus.len   = 4'd6;
      stepCycle();
      bus.start = 1'b0;
      stepCycle();
      stepCycle();
      ready_force = 1'b0;
      for (int i = 0; i < 5; i++) begin
         stepCycle();
         checkOutput("bp_valid", bus.res_valid, 1);
         checkOutput("bp_data", bus.res_data, 13);
         checkOutput("bp_idx", bus.res_idx, 1);
         checkOutput("bp_rs", bus.rs_out, 2);
      end
      ready_force = 1'b1;
      stepCycle();
      checkOutput("bp_accept_drop", bus.res_valid, 0);
      stepCycle();
      checkOutput("bp_next_valid", bus.res_valid, 1);
      checkOutput("bp_next_idx", bus.res_idx, 2);
      checkOutput("bp_next_data", bus.res_data, 12);
      c = 0;
      seen = 1'b0;
      while (!seen && c < 100) begin
         stepCycle();
         c++;
         seen = bus.done;
      end
      checkOutput("bp_done_seen", seen, 1);
      checkOutput("bp_sb_drained", sb_q.size(), 0);
   endtask

   // Reset while idx3 is waiting for acceptance.
   task automatic applyMidRunReset();
      queueRun(6);
      bus.start = 1'b1;
      bus.len   = 4'd6;
      stepCycle();
      bus.start = 1'b0;
      for (int i = 0; i < 6; i++) stepCycle();
      ready_force = 1'b0;
      stepCycle();
      checkOutput("rr_valid_idx3", bus.res_valid, 1);
      checkOutput("rr_idx", bus.res_idx, 3);
      rst_n = 1'b0;
      stepCycle();
      rst_n = 1'b1;
      ready_force = 1'b1;
      sb_q.delete();
      for (int i = 0; i < 8; i++) shadow[i] = '0;
      checkIdle("rr");
      stepCycle();
      checkOutput("rr_stays_idle_valid", bus.res_valid, 0);
      checkOutput("rr_stays_idle_busy", bus.busy, 0);
   endtask

   // Watchdog so a stuck design still ends the run.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_sel  = '0;
      bus.wr_rs   = '0;
      bus.wr_rt   = '0;
      bus.start   = 1'b0;
      bus.len     = '0;

      $display("[TB] reset and idle outputs");
      applyReset();
      checkIdle("reset");

      $display("[TB] len=1 on cleared program");
      applyStimulus(1, 1'b1, 1'b0, 1'b0);

      $display("[TB] demo program, len=6");
      loadDemo();
      applyStimulus(6, 1'b1, 1'b0, 1'b0);

      $display("[TB] backpressure on idx1");
      applyBackpressure();

      $display("[TB] len=0");
      applyStimulus(0, 1'b0, 1'b0, 1'b0);

      $display("[TB] write and start while busy");
      applyStimulus(6, 1'b1, 1'b1, 1'b0);

      $display("[TB] write on the start edge reads old entry");
      applyStimulus(2, 1'b1, 1'b0, 1'b1);
      applyStimulus(1, 1'b1, 1'b0, 1'b0);

      $display("[TB] reset during a run");
      loadDemo();
      applyMidRunReset();
      applyStimulus(1, 1'b1, 1'b0, 1'b0);

      $display("[TB] randomized programs");
      for (int iter = 0; iter < 10; iter++) begin
         for (int a = 0; a < 8; a++) begin
            writeEntry(a, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
         end
         rand_ready = iter[0];
         applyStimulus(int'($urandom_range(0, 15)), !rand_ready, 1'b0, 1'b0);
         rand_ready = 1'b0;
         stepCycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dae_issuer.md
Name: dae_issuer

Overview:
- Sequencer that drives the instruction side of the 4-bit decode-and-execute ALU.
- Holds a small program of {sel, rs, rt} triples, loaded through a write port.
- On start, issues the triples one at a time on rs_out/rt_out/sel_out, samples the ALU's combinational rd after one settle cycle, and returns each result on a valid/ready result port.
- It is the initiator end of the ALU's rs/rt/sel -> rd interface. It lets a board or bench exercise the ALU from a stored program instead of switches.

Parameters:
- PROG_DEPTH, 8, number of program entries; index width is 3 bits.
- DATA_W, 4, width of rs, rt and rd.
- OP_W, 3, width of sel.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- wr_en  in  1  program write strobe; ignored while busy.
- wr_addr  in  3  program entry to write.
- wr_sel  in  OP_W  opcode to store.
- wr_rs  in  DATA_W  rs operand to store.
- wr_rt  in  DATA_W  rt operand to store.
- start  in  1  begin a run; sampled only in IDLE.
- len  in  4  number of entries to run, 0..8, sampled with start.
- rs_out  out  DATA_W  registered rs to the ALU.
- rt_out  out  DATA_W  registered rt to the ALU.
- sel_out  out  OP_W  registered sel to the ALU.
- rd_in  in  DATA_W  ALU result (combinational from rs_out/rt_out/sel_out).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_idx  out  3  program index of the presented result.
- res_data  out  DATA_W  captured rd.
- busy  out  1  run in progress.
- done  out  1  sticky run-complete flag.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE, pc=0.
  - All outputs go to 0: rs_out, rt_out, sel_out, res_valid, res_idx, res_data, busy, done.
  - All 8 program entries are cleared to 0.
  - Reset mid-run aborts the run immediately. No further result is presented.
- Program writes:
  - At an edge where wr_en=1 and busy=0, mem[wr_addr] <= {wr_sel, wr_rs, wr_rt}.
  - wr_en while busy=1 is dropped.
- States: IDLE, SETTLE, HOLD.
- IDLE, start=1, len=0: done<=1, busy stays 0, no result is presented.
- IDLE, start=1, len in 1..8:
  - pc<=0, done<=0, busy<=1.
  - {sel_out, rs_out, rt_out} <= mem[0].
  - -> SETTLE.
  - len values 9..15 are clamped to 8.
- SETTLE (exactly one cycle, letting the ALU settle):
  - res_data<=rd_in, res_idx<=pc, res_valid<=1.
  - -> HOLD.
- HOLD:
  - While res_ready=0: res_valid, res_data, res_idx and the operand outputs hold unchanged.
  - On an edge with res_valid=1 and res_ready=1: res_valid<=0.
  - If pc==len-1: busy<=0, done<=1, -> IDLE.
  - Otherwise: pc<=pc+1, load mem[pc+1] into the operand outputs, -> SETTLE.
- start in SETTLE or HOLD is ignored. len is latched at start; changes during a run have no effect.
- Operand outputs keep the last issued entry after a run completes.
- done stays high until the next accepted start, which clears it on that edge.
- Latency, with res_ready held at 1:
  - Let E0 be the start edge.
  - Result k is visible after edge E(2k+1) for one cycle.
  - done rises after edge E(2N) for a run of length N.
- A write to an entry during IDLE is visible to a start on the following edge. No write/start bypass on the same edge: start on the same edge reads the old entry.
- ALU sel encoding assumed by benches (4-bit wraparound):
  - 0: rs-rt
  - 1: rs+rt
  - 2: OR
  - 3: AND
  - 4: arithmetic right shift of rt
  - 5: rotate-left of rs
  - 6: {1,0,1,rs<rt}
  - 7: {1,1,1,rs==rt}

Test Plan:
- Reset then idle: all outputs 0. start with len=1 and mem cleared -> res_data=0 with sel 0, rs 0, rt 0. A behavioural ALU (rd = rs-rt) is attached to rd_in. done=1 after 2 cycles.
- Load 6 entries (sel1 rs3 rt4, sel0 rs2 rt5, sel4 rt8, sel5 rs9, sel6 rs2 rt5, sel7 rs5 rt5), res_ready=1, start len=6:
  - Results in order: idx0=7, idx1=13, idx2=12, idx3=3, idx4=11, idx5=15.
  - res_valid is high every other cycle; done=1 at E12.
- Backpressure: same program, res_ready=0 for 5 cycles on idx1:
  - res_valid, res_data=13 and rs_out=2 all stay stable.
  - idx2 appears 2 cycles after the accept.
- start with len=0 -> done=1 next edge, busy never 1, no res_valid.
- Writes and start during a run: wr_en to addr 2 and start=1 while busy -> both ignored; idx2 result is still 12 and the run length is unchanged.
- rst_n=0 during HOLD of idx3 -> next cycle all outputs 0 and state IDLE. A later start len=1 returns 0, since memory was cleared.
